i_cache_axi_rd: RTL and testbench

- Memory-side responder for the instruction cache refill port. Accepts the cache's level-held read request on cache_read_ena/cache_addr.
- Issues one single-beat AXI4 read on the master AR/R channels and returns the selected 32-bit instruction word on cache_or_data with a one-cycle cache_in_ok pulse.
- Sits between i_cache1 and the AXI4 interconnect/arbiter; one outstanding transaction at a time.

---
 rtl/i_cache_axi_rd_pkg.sv | 44 ++++
 rtl/i_cache_axi_rd_if.sv | 45 ++++
 rtl/i_cache_axi_rd.sv | 171 +++++++++++++++++
 tb/tb_i_cache_axi_rd.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i_cache_axi_rd_pkg.sv
// -----------------------------------------------------------------------------
// i_cache_axi_rd_pkg
//
// Shared constants for the instruction-cache AXI read responder:
//   - one-hot FSM state encodings (IAXI_IDLE/AR/R/DONE/HOLD, 5 bits)
//   - AXI4 attribute constants (transfer size, burst type, response codes)
//   - the RISC-V NOP word returned in place of data on an errored refill
//   - small helpers for word selection and response classification
// -----------------------------------------------------------------------------
package i_cache_axi_rd_pkg;

   localparam int unsigned IAXI_STATE_W = 5;

   typedef logic [IAXI_STATE_W-1:0] iaxi_state_t;

   // One-hot state encodings
   localparam logic [4:0] IAXI_IDLE = 5'b00001;
   localparam logic [4:0] IAXI_AR   = 5'b00010;
   localparam logic [4:0] IAXI_R    = 5'b00100;
   localparam logic [4:0] IAXI_DONE = 5'b01000;
   localparam logic [4:0] IAXI_HOLD = 5'b10000;

   // AXI4 attribute constants
   localparam logic [2:0] SIZE_8B     = 3'b011;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   // Pick the 32-bit instruction out of an 8-byte beat using byte-address bit 2.
   function automatic logic [31:0] select_word(input logic hi, input logic [63:0] beat);
      return hi ? beat[63:32] : beat[31:0];
   endfunction

   // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

endpackage

// File: rtl/i_cache_axi_rd_if.sv
// -----------------------------------------------------------------------------
// i_cache_axi_rd_if
//
// AXI4 read-address / read-data channel bundle used on the instruction-cache
// refill path.
//   master modport : drives AR (valid/addr/id/len/size/burst) and R ready
//   slave  modport : drives AR ready and R (valid/data/resp/last/id)
//
// Parameters:
//   AXI_ID_W   : width of ar_id / r_id
//   AXI_ADDR_W : width of ar_addr
// -----------------------------------------------------------------------------
interface i_cache_axi_rd_if #(
   parameter int unsigned AXI_ID_W   = 4,
   parameter int unsigned AXI_ADDR_W = 64
);

   // AR channel
   logic                  ar_valid;
   logic                  ar_ready;
   logic [AXI_ADDR_W-1:0] ar_addr;
   logic [AXI_ID_W-1:0]   ar_id;
   logic [7:0]            ar_len;
   logic [2:0]            ar_size;
   logic [1:0]            ar_burst;

   // R channel
   logic                  r_valid;
   logic                  r_ready;
   logic [63:0]           r_data;
   logic [1:0]            r_resp;
   logic                  r_last;
   logic [AXI_ID_W-1:0]   r_id;

   modport master (
      output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, r_ready,
      input  ar_ready, r_valid, r_data, r_resp, r_last, r_id
   );

   modport slave (
      input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, r_ready,
      output ar_ready, r_valid, r_data, r_resp, r_last, r_id
   );

endinterface

// File: rtl/i_cache_axi_rd.sv
// -----------------------------------------------------------------------------
// i_cache_axi_rd
//
// Memory-side responder for the instruction-cache refill port. Takes the
// cache's level-held read request, issues one single-beat AXI4 read, and
// returns the addressed 32-bit instruction with a one-cycle cache_in_ok pulse.
// One transaction is outstanding at a time.
//
// Optional build macro: YSYX22040228_IAXI_ERR_EN
//   When defined, adds cache_rd_err, which pulses with cache_in_ok when the beat
//   came back SLVERR/DECERR; the returned word is then forced to a NOP.
//
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   cache_read_ena  : refill request, held by the cache until cache_in_ok
//   cache_addr      : 64-bit instruction byte address (4-byte aligned)
//   cache_or_data   : returned instruction word, zero unless cache_in_ok
//   cache_in_ok     : one-cycle completion pulse
//   cache_rd_err    : (macro only) error flag alongside cache_in_ok
//   axi             : AXI4 AR/R master (i_cache_axi_rd_if.master)
//
// Parameters:
//   AXI_ID_W   : width of ar_id / r_id
//   AXI_ID     : constant ID driven on ar_id
//   AXI_ADDR_W : AXI address width
// -----------------------------------------------------------------------------
module i_cache_axi_rd
   import i_cache_axi_rd_pkg::*;
#(
   parameter int unsigned AXI_ID_W   = 4,
   parameter int unsigned AXI_ID     = 0,
   parameter int unsigned AXI_ADDR_W = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cache_read_ena,
   input  logic [63:0]            cache_addr,
   output logic [31:0]            cache_or_data,
   output logic                   cache_in_ok,
`ifdef YSYX22040228_IAXI_ERR_EN
   output logic                   cache_rd_err,
`endif
   i_cache_axi_rd_if.master       axi
);

   logic [4:0]  state_q, state_d;
   logic [63:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   // Set when the cache withdraws its request mid-transaction; the AXI side
   // still runs to completion but the completion pulse is skipped.
   logic        abandon_q, abandon_d;
`ifdef YSYX22040228_IAXI_ERR_EN
   logic        err_q, err_d;
`endif

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      abandon_d = abandon_q;
`ifdef YSYX22040228_IAXI_ERR_EN
      err_d     = err_q;
`endif

      unique case (state_q)
         IAXI_IDLE: begin
            abandon_d = 1'b0;
            if (cache_read_ena) begin
               addr_d  = cache_addr;
               state_d = IAXI_AR;
            end
         end

         IAXI_AR: begin
            if (!cache_read_ena) begin
               abandon_d = 1'b1;
            end
            // AR is never withdrawn once raised
            if (axi.ar_ready) begin
               state_d = IAXI_R;
            end
         end

         IAXI_R: begin
            if (!cache_read_ena) begin
               abandon_d = 1'b1;
            end
            // ar_len is 0, so the first beat is the last regardless of r_last
            if (axi.r_valid) begin
`ifdef YSYX22040228_IAXI_ERR_EN
               err_d  = resp_is_err(axi.r_resp);
               data_d = resp_is_err(axi.r_resp) ? NOP_INSN
                                                : select_word(addr_q[2], axi.r_data);
`else
               data_d = select_word(addr_q[2], axi.r_data);
`endif
               state_d = (abandon_q || !cache_read_ena) ? IAXI_HOLD : IAXI_DONE;
            end
         end

         IAXI_DONE: begin
            state_d = IAXI_HOLD;
         end

         // Cache's request register is still high this cycle; ignore it.
         IAXI_HOLD: begin
            state_d = IAXI_IDLE;
         end

         default: begin
            state_d = IAXI_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IAXI_IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         abandon_q <= 1'b0;
`ifdef YSYX22040228_IAXI_ERR_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         abandon_q <= abandon_d;
`ifdef YSYX22040228_IAXI_ERR_EN
         err_q     <= err_d;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: decoded from registered state only
   // ---------------------------------------------------------------------------
   assign axi.ar_valid = (state_q == IAXI_AR);
   assign axi.ar_addr  = AXI_ADDR_W'({addr_q[63:3], 3'b000});
   assign axi.ar_id    = AXI_ID_W'(AXI_ID);
   assign axi.ar_len   = 8'd0;
   assign axi.ar_size  = SIZE_8B;
   assign axi.ar_burst = BURST_INCR;
   assign axi.r_ready  = (state_q == IAXI_R);

   assign cache_in_ok   = (state_q == IAXI_DONE);
   assign cache_or_data = cache_in_ok ? data_q : 32'h0;
`ifdef YSYX22040228_IAXI_ERR_EN
   assign cache_rd_err  = cache_in_ok & err_q;
`endif

   // Inputs that are intentionally not observed by the datapath
   logic unused_sig;
   assign unused_sig = ^{axi.r_last, axi.r_id, axi.r_resp, addr_q[1:0]};

   // ---------------------------------------------------------------------------
   // Assertions
   // ---------------------------------------------------------------------------
   a_state_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot(state_q));

   a_ar_stable : assert property (@(posedge clk) disable iff (!rst)
      (axi.ar_valid && !axi.ar_ready) |=> (axi.ar_valid && $stable(axi.ar_addr)));

endmodule

// File: tb/tb_i_cache_axi_rd.sv
// -----------------------------------------------------------------------------
// tb_i_cache_axi_rd
//
// Directed bench for i_cache_axi_rd. The stimulus process plays both the cache
// and the AXI slave; expected AR addresses and returned words are queued when
// a request is issued and a negedge monitor pops and compares them whenever the
// DUT handshakes AR or pulses cache_in_ok.
// -----------------------------------------------------------------------------
module tb_i_cache_axi_rd;
   import i_cache_axi_rd_pkg::*;

   typedef struct packed {
      logic [31:0] word;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        cache_read_ena;
   logic [63:0] cache_addr;
   logic [31:0] cache_or_data;
   logic        cache_in_ok;
`ifdef YSYX22040228_IAXI_ERR_EN
   logic        cache_rd_err;
`endif

   i_cache_axi_rd_if #(.AXI_ID_W(4), .AXI_ADDR_W(64)) axi ();

   i_cache_axi_rd #(
      .AXI_ID_W   (4),
      .AXI_ID     (0),
      .AXI_ADDR_W (64)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cache_read_ena (cache_read_ena),
      .cache_addr     (cache_addr),
      .cache_or_data  (cache_or_data),
      .cache_in_ok    (cache_in_ok),
`ifdef YSYX22040228_IAXI_ERR_EN
      .cache_rd_err   (cache_rd_err),
`endif
      .axi            (axi)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int n_ok  = 0;
   int n_exp_ok = 0;
   int cyc = 0;

   logic [63:0] exp_ar_q[$];
   exp_t        exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Monitor / scoreboard
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst) begin
         if (axi.ar_valid && exp_ar_q.size() != 0) begin
            check("ar_addr", axi.ar_addr, exp_ar_q[0]);
         end
         if (axi.ar_valid && axi.ar_ready) begin
            check("ar_expected", 64'(exp_ar_q.size() != 0), 64'd1);
            if (exp_ar_q.size() != 0) begin
               void'(exp_ar_q.pop_front());
               check("ar_attr", {axi.ar_id, axi.ar_len, axi.ar_size, axi.ar_burst},
                     {4'd0, 8'd0, 3'b011, 2'b01});
            end
         end
         if (cache_in_ok) begin
            n_ok++;
            check("ok_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("or_data", cache_or_data, e.word);
`ifdef YSYX22040228_IAXI_ERR_EN
               check("rd_err", cache_rd_err, e.err);
`endif
            end
         end else begin
            check("or_data_idle", cache_or_data, 64'd0);
`ifdef YSYX22040228_IAXI_ERR_EN
            check("rd_err_idle", cache_rd_err, 64'd0);
`endif
         end
      end
   end

   // ---------------------------------------------------------------------------
   // One refill: cache request + AXI slave responses with given delays.
   // ---------------------------------------------------------------------------
   task automatic do_txn(input logic [63:0] addr, input logic [63:0] rdata,
                         input logic [1:0] resp, input logic last,
                         input int ar_dly, input int r_dly, input bit abandon,
                         input logic [31:0] exp_word, input logic exp_err,
                         output int lat);
      int start;
      int waited;
      lat = -1;
      exp_ar_q.push_back({addr[63:3], 3'b000});
      if (!abandon) begin
         exp_q.push_back('{word: exp_word, err: exp_err});
         n_exp_ok++;
      end
      cache_read_ena = 1'b1;
      cache_addr     = addr;
      start          = cyc;

      waited = 0;
      while (!axi.ar_valid && waited < 20) begin
         step();
         waited++;
      end
      if (!axi.ar_valid) begin
         check("ar_valid_timeout", 64'(axi.ar_valid), 64'd1);
         cache_read_ena = 1'b0;
         return;
      end

      // A beat offered outside R must not be accepted
      if (ar_dly > 0) begin
         axi.r_valid = 1'b1;
         axi.r_data  = 64'hBADB_AD00_BADB_AD00;
         check("r_ready_in_ar", 64'(axi.r_ready), 64'd0);
         repeat (ar_dly) step();
         axi.r_valid = 1'b0;
      end
      axi.ar_ready = 1'b1;
      step();
      axi.ar_ready = 1'b0;

      if (abandon) cache_read_ena = 1'b0;
      repeat (r_dly) step();
      axi.r_valid = 1'b1;
      axi.r_data  = rdata;
      axi.r_resp  = resp;
      axi.r_last  = last;
      check("r_ready_on_beat", 64'(axi.r_ready), 64'd1);
      step();
      axi.r_valid = 1'b0;
      axi.r_last  = 1'b1;
      axi.r_resp  = 2'b00;

      if (abandon) begin
         check("ok_suppressed", 64'(cache_in_ok), 64'd0);
         step();
      end else begin
         check("ok_pulse", 64'(cache_in_ok), 64'd1);
         lat = cyc - start;
         step();
         check("ok_single", 64'(cache_in_ok), 64'd0);
         step();
         cache_read_ena = 1'b0;
      end
      step();
      step();
      check("no_second_ar", 64'(axi.ar_valid), 64'd0);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin : stim
      int lat;
      rst            = 1'b0;
      cache_read_ena = 1'b0;
      cache_addr     = '0;
      axi.ar_ready   = 1'b0;
      axi.r_valid    = 1'b0;
      axi.r_data     = '0;
      axi.r_resp     = 2'b00;
      axi.r_last     = 1'b1;
      axi.r_id       = '0;

      step();
      step();
      check("rst_ar_valid", 64'(axi.ar_valid), 64'd0);
      check("rst_r_ready", 64'(axi.r_ready), 64'd0);
      check("rst_in_ok", 64'(cache_in_ok), 64'd0);
      check("rst_or_data", cache_or_data, 64'd0);
      check("rst_state", dut.state_q, IAXI_IDLE);
      rst = 1'b1;
      step();

      // Basic low word, minimum latency
      do_txn(64'h8000_0000, 64'h1111_2222_3333_4444, 2'b00, 1'b1, 0, 0, 1'b0,
             32'h3333_4444, 1'b0, lat);
      check("latency_min", 64'(lat), 64'd3);

      // High word with AR and R backpressure
      do_txn(64'h8000_0104, 64'hDEAD_BEEF_0000_0000, 2'b00, 1'b1, 4, 6, 1'b0,
             32'hDEAD_BEEF, 1'b0, lat);

      // Abandon in R, then a normal request
      do_txn(64'h8000_0020, 64'h5555_6666_7777_8888, 2'b00, 1'b1, 0, 2, 1'b1,
             32'h0, 1'b0, lat);
      do_txn(64'h8000_0008, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b1, 0, 0, 1'b0,
             32'h89AB_CDEF, 1'b0, lat);

      // r_last low on the only beat
      do_txn(64'h8000_000C, 64'hCAFE_F00D_1234_5678, 2'b00, 1'b0, 1, 2, 1'b0,
             32'hCAFE_F00D, 1'b0, lat);

`ifdef YSYX22040228_IAXI_ERR_EN
      do_txn(64'h8000_0040, 64'h9999_AAAA_BBBB_CCCC, 2'b11, 1'b1, 0, 1, 1'b0,
             32'h0000_0013, 1'b1, lat);
      do_txn(64'h8000_0044, 64'h9999_AAAA_BBBB_CCCC, 2'b00, 1'b1, 0, 0, 1'b0,
             32'h9999_AAAA, 1'b0, lat);
`else
      // Error response is ignored in the default build
      do_txn(64'h8000_0040, 64'h9999_AAAA_BBBB_CCCC, 2'b10, 1'b1, 0, 1, 1'b0,
             32'hBBBB_CCCC, 1'b0, lat);
`endif

      // Reset while AR is pending
      cache_read_ena = 1'b1;
      cache_addr     = 64'h8000_0080;
      step();
      check("mid_ar_valid_pre", 64'(axi.ar_valid), 64'd1);
      rst = 1'b0;
      #1;
      check("mid_rst_ar_valid", 64'(axi.ar_valid), 64'd0);
      check("mid_rst_r_ready", 64'(axi.r_ready), 64'd0);
      check("mid_rst_in_ok", 64'(cache_in_ok), 64'd0);
      check("mid_rst_state", dut.state_q, IAXI_IDLE);
      cache_read_ena = 1'b0;
      step();
      rst = 1'b1;
      step();

      // Recovery after reset
      do_txn(64'h8000_0004, 64'h0000_0001_0000_0002, 2'b00, 1'b1, 0, 0, 1'b0,
             32'h0000_0001, 1'b0, lat);

      step();
      check("ok_count", 64'(n_ok), 64'(n_exp_ok));
      check("sb_ar_left", 64'(exp_ar_q.size()), 64'd0);
      check("sb_data_left", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
